// File: rtl/biriscv_dmem_responder.sv
// Memory-side responder for the riscv_core data port: word array with byte-strobed stores,
// error classification and an in-order response FIFO returning acks after a fixed latency.
module biriscv_dmem_responder #(
    parameter int          MEM_WORDS   = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h80000000,
    parameter int          LATENCY     = 2,
    parameter int          QUEUE_DEPTH = 4,
    parameter int          TAG_W       = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      mem_d_addr_i,
    input  logic [31:0]      mem_d_data_wr_i,
    input  logic             mem_d_rd_i,
    input  logic [3:0]       mem_d_wr_i,
    input  logic             mem_d_cacheable_i,
    input  logic [TAG_W-1:0] mem_d_req_tag_i,
    input  logic             mem_d_invalidate_i,
    input  logic             mem_d_writeback_i,
    input  logic             mem_d_flush_i,
    input  logic             stall_i,
    output logic             mem_d_accept_o,
    output logic             mem_d_ack_o,
    output logic             mem_d_error_o,
    output logic [31:0]      mem_d_data_rd_o,
    output logic [TAG_W-1:0] mem_d_resp_tag_o
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0]      MEM_BYTES = 32'(4 * MEM_WORDS);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(QUEUE_DEPTH);
    localparam logic [CD_W-1:0]  CD_INIT   = CD_W'(LATENCY - 1);

    logic [31:0] mem [MEM_WORDS];

    logic [31:0]      off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             wr_any;
    logic             rw;
    logic [2:0]       nclass;
    logic             req;
    logic             accept;
    logic             push;
    logic             pop;
    logic             err_in;
    logic             we;
    logic [31:0]      rdata_in;
    logic [31:0]      old_word;
    logic [31:0]      merged;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             err_f   [QUEUE_DEPTH];
    logic [31:0]      rdata_f [QUEUE_DEPTH];
    logic [TAG_W-1:0] tag_f   [QUEUE_DEPTH];
    logic [CD_W-1:0]  cd_f    [QUEUE_DEPTH];

    logic             vld_p1;
    logic             err_p1;
    logic [31:0]      rdata_p1;
    logic [TAG_W-1:0] tag_p1;

    logic unused_cacheable;
    assign unused_cacheable = mem_d_cacheable_i;

    // Request decode and classification
    always_comb begin
        off      = mem_d_addr_i - BASE_ADDR;
        in_range = (mem_d_addr_i >= BASE_ADDR) && (off < MEM_BYTES);
        idx      = off[IDX_W+1:2];
        wr_any   = |mem_d_wr_i;
        rw       = mem_d_rd_i | wr_any;
        nclass   = 3'(rw) + 3'(mem_d_invalidate_i) + 3'(mem_d_writeback_i) + 3'(mem_d_flush_i);
        req      = rw | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
        accept   = !rst_i && !stall_i && (count < DEPTH_C);
        push     = req && accept;
        pop      = (count != '0) && (cd_f[rd_ptr] == '0);
        // Range errors only concern array accesses; maintenance ops never touch the array
        err_in   = (nclass > 3'd1) | (mem_d_rd_i & wr_any) | (rw & !in_range);
        we       = push & wr_any & !err_in;
        old_word = mem[idx];
        rdata_in = (mem_d_rd_i && !err_in) ? old_word : '0;
        merged   = {mem_d_wr_i[3] ? mem_d_data_wr_i[31:24] : old_word[31:24],
                    mem_d_wr_i[2] ? mem_d_data_wr_i[23:16] : old_word[23:16],
                    mem_d_wr_i[1] ? mem_d_data_wr_i[15:8]  : old_word[15:8],
                    mem_d_wr_i[0] ? mem_d_data_wr_i[7:0]   : old_word[7:0]};
    end

    always_ff @(posedge clk_i) begin
        if (we) mem[idx] <= merged;
    end

    // Response FIFO payload: every countdown ticks toward zero, the new entry overrides its slot
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (cd_f[PTR_W'(i)] != '0) cd_f[PTR_W'(i)] <= cd_f[PTR_W'(i)] - 1'b1;
        end
        if (push) begin
            cd_f[wr_ptr]    <= CD_INIT;
            err_f[wr_ptr]   <= err_in;
            rdata_f[wr_ptr] <= rdata_in;
            tag_f[wr_ptr]   <= mem_d_req_tag_i;
        end
    end

    // Response stage: head pops into the registered ack outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
            tag_p1   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            vld_p1   <= pop;
            err_p1   <= pop & err_f[rd_ptr];
            rdata_p1 <= pop ? rdata_f[rd_ptr] : '0;
            tag_p1   <= pop ? tag_f[rd_ptr] : '0;
        end
    end

    assign mem_d_accept_o   = accept;
    assign mem_d_ack_o      = vld_p1;
    assign mem_d_error_o    = err_p1;
    assign mem_d_data_rd_o  = rdata_p1;
    assign mem_d_resp_tag_o = tag_p1;

endmodule

// File: tb/tb_biriscv_dmem_responder.sv
// Directed bench for biriscv_dmem_responder: default instance plus a long-latency instance
// used to fill the response queue.
module tb_biriscv_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        rd;
    logic [3:0]  wr;
    logic [10:0] req_tag;
    logic        inv;
    logic        wb;
    logic        fl;
    logic        stall;
    logic        accept;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [10:0] resp_tag;

    logic [31:0] q_addr;
    logic        q_rd;
    logic [10:0] q_tag;
    logic        q_accept;
    logic        q_ack;
    logic        q_err;
    logic [31:0] q_rdata;
    logic [10:0] q_resp_tag;

    int n_checks = 0;
    int n_fail   = 0;

    biriscv_dmem_responder dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mem_d_addr_i       (addr),
        .mem_d_data_wr_i    (data_wr),
        .mem_d_rd_i         (rd),
        .mem_d_wr_i         (wr),
        .mem_d_cacheable_i  (1'b1),
        .mem_d_req_tag_i    (req_tag),
        .mem_d_invalidate_i (inv),
        .mem_d_writeback_i  (wb),
        .mem_d_flush_i      (fl),
        .stall_i            (stall),
        .mem_d_accept_o     (accept),
        .mem_d_ack_o        (ack),
        .mem_d_error_o      (err),
        .mem_d_data_rd_o    (rdata),
        .mem_d_resp_tag_o   (resp_tag)
    );

    biriscv_dmem_responder #(.LATENCY(8)) dut_q (
        .clk_i              (clk),
        .rst_i              (rst),
        .mem_d_addr_i       (q_addr),
        .mem_d_data_wr_i    (32'h0),
        .mem_d_rd_i         (q_rd),
        .mem_d_wr_i         (4'h0),
        .mem_d_cacheable_i  (1'b0),
        .mem_d_req_tag_i    (q_tag),
        .mem_d_invalidate_i (1'b0),
        .mem_d_writeback_i  (1'b0),
        .mem_d_flush_i      (1'b0),
        .stall_i            (1'b0),
        .mem_d_accept_o     (q_accept),
        .mem_d_ack_o        (q_ack),
        .mem_d_error_o      (q_err),
        .mem_d_data_rd_o    (q_rdata),
        .mem_d_resp_tag_o   (q_resp_tag)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rd = 1'b0; wr = 4'h0; inv = 1'b0; wb = 1'b0; fl = 1'b0;
        addr = 32'h0; data_wr = 32'h0; req_tag = 11'h0;
    endtask

    // One request followed by idle cycles; returns what the outputs showed one edge before
    // and exactly at the expected ack edge.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic r,
                       input logic [3:0] w, input logic [2:0] m, input logic [10:0] t,
                       output logic acc, output logic early, output logic k,
                       output logic e, output logic [31:0] rv, output logic [10:0] tg);
        addr = a; data_wr = d; rd = r; wr = w; inv = m[2]; wb = m[1]; fl = m[0]; req_tag = t;
        #1;
        acc = accept;
        tick;
        idle;
        tick;
        early = ack;
        tick;
        k = ack; e = err; rv = rdata; tg = resp_tag;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0h want 0", ack); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", err); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_checks++; if (resp_tag !== 11'h0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", resp_tag); end
        n_checks++; if (accept !== 1'b0) begin n_fail++; $display("FAIL reset_accept: got %0h want 0", accept); end
        n_checks++; if (q_ack !== 1'b0) begin n_fail++; $display("FAIL reset_q_ack: got %0h want 0", q_ack); end
        n_checks++; if (q_accept !== 1'b0) begin n_fail++; $display("FAIL reset_q_accept: got %0h want 0", q_accept); end
        rst = 1'b0;
        #1;
        n_checks++; if (accept !== 1'b1) begin n_fail++; $display("FAIL post_reset_accept: got %0h want 1", accept); end
    endtask

    task automatic test_store_load;
        addr = 32'h80000010; data_wr = 32'hDEADBEEF; wr = 4'hF; req_tag = 11'd5;
        #1;
        n_checks++; if (accept !== 1'b1) begin n_fail++; $display("FAIL sl_accept_st: got %0h want 1", accept); end
        tick;
        wr = 4'h0; rd = 1'b1; req_tag = 11'd6;
        #1;
        n_checks++; if (accept !== 1'b1) begin n_fail++; $display("FAIL sl_accept_ld: got %0h want 1", accept); end
        tick;
        idle;
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL sl_early_ack: got %0h want 0", ack); end
        tick;
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL sl_st_ack: got %0h want 1", ack); end
        n_checks++; if (resp_tag !== 11'd5) begin n_fail++; $display("FAIL sl_st_tag: got %0d want 5", resp_tag); end
        n_checks++; if (err !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL sl_st_fields: got err %0h rdata %h want 0/0", err, rdata); end
        tick;
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL sl_ld_ack: got %0h want 1", ack); end
        n_checks++; if (resp_tag !== 11'd6) begin n_fail++; $display("FAIL sl_ld_tag: got %0d want 6", resp_tag); end
        n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sl_ld_rdata: got %h want deadbeef", rdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sl_ld_err: got %0h want 0", err); end
        tick;
        n_checks++; if (ack !== 1'b0 || resp_tag !== 11'h0 || rdata !== 32'h0 || err !== 1'b0) begin
            n_fail++; $display("FAIL sl_idle_zero: got ack %0h tag %h rdata %h err %0h want all 0", ack, resp_tag, rdata, err);
        end
    endtask

    task automatic test_byte_strobe;
        logic acc, early, k, e;
        logic [31:0] rv;
        logic [10:0] tg;
        txn(32'h80000020, 32'h11223344, 1'b0, 4'hF, 3'b000, 11'd7, acc, early, k, e, rv, tg);
        n_checks++; if (k !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL bs_init_store: got ack %0h err %0h want 1/0", k, e); end
        txn(32'h80000020, 32'h00AA0000, 1'b0, 4'b0100, 3'b000, 11'd8, acc, early, k, e, rv, tg);
        n_checks++; if (acc !== 1'b1 || tg !== 11'd8) begin n_fail++; $display("FAIL bs_store: got acc %0h tag %0d want 1/8", acc, tg); end
        txn(32'h80000020, 32'h0, 1'b1, 4'h0, 3'b000, 11'd9, acc, early, k, e, rv, tg);
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL bs_early: got %0h want 0", early); end
        n_checks++; if (rv !== 32'h11AA3344) begin n_fail++; $display("FAIL bs_lane2: got %h want 11aa3344", rv); end
        n_checks++; if (tg !== 11'd9) begin n_fail++; $display("FAIL bs_tag: got %0d want 9", tg); end
        txn(32'h80000020, 32'hEE0000FF, 1'b0, 4'b1001, 3'b000, 11'd1, acc, early, k, e, rv, tg);
        txn(32'h80000020, 32'h0, 1'b1, 4'h0, 3'b000, 11'd2, acc, early, k, e, rv, tg);
        n_checks++; if (rv !== 32'hEEAA33FF) begin n_fail++; $display("FAIL bs_lanes03: got %h want eeaa33ff", rv); end
    endtask

    task automatic test_range;
        logic acc, early, k, e;
        logic [31:0] rv;
        logic [10:0] tg;
        txn(32'h80003FFC, 32'hCAFEF00D, 1'b0, 4'hF, 3'b000, 11'd3, acc, early, k, e, rv, tg);
        txn(32'h80000000, 32'h01020304, 1'b0, 4'hF, 3'b000, 11'd4, acc, early, k, e, rv, tg);
        txn(32'h7FFFFFFC, 32'h0, 1'b1, 4'h0, 3'b000, 11'd10, acc, early, k, e, rv, tg);
        n_checks++; if (k !== 1'b1 || e !== 1'b1) begin n_fail++; $display("FAIL rng_low_err: got ack %0h err %0h want 1/1", k, e); end
        n_checks++; if (rv !== 32'h0 || tg !== 11'd10) begin n_fail++; $display("FAIL rng_low_fields: got rdata %h tag %0d want 0/10", rv, tg); end
        txn(32'h80004000, 32'h55555555, 1'b0, 4'hF, 3'b000, 11'd11, acc, early, k, e, rv, tg);
        n_checks++; if (e !== 1'b1 || rv !== 32'h0) begin n_fail++; $display("FAIL rng_high_err: got err %0h rdata %h want 1/0", e, rv); end
        txn(32'h80003FFC, 32'h0, 1'b1, 4'h0, 3'b000, 11'd12, acc, early, k, e, rv, tg);
        n_checks++; if (rv !== 32'hCAFEF00D || e !== 1'b0) begin n_fail++; $display("FAIL rng_last_word: got %h err %0h want cafef00d/0", rv, e); end
        txn(32'h80000000, 32'h0, 1'b1, 4'h0, 3'b000, 11'd13, acc, early, k, e, rv, tg);
        n_checks++; if (rv !== 32'h01020304) begin n_fail++; $display("FAIL rng_word0: got %h want 01020304", rv); end
    endtask

    task automatic test_errors;
        logic acc, early, k, e;
        logic [31:0] rv;
        logic [10:0] tg;
        txn(32'h80000010, 32'h12345678, 1'b1, 4'hF, 3'b000, 11'd12, acc, early, k, e, rv, tg);
        n_checks++; if (e !== 1'b1 || rv !== 32'h0) begin n_fail++; $display("FAIL err_rdwr: got err %0h rdata %h want 1/0", e, rv); end
        txn(32'h80000010, 32'h0, 1'b1, 4'h0, 3'b100, 11'd13, acc, early, k, e, rv, tg);
        n_checks++; if (e !== 1'b1 || rv !== 32'h0) begin n_fail++; $display("FAIL err_rd_inv: got err %0h rdata %h want 1/0", e, rv); end
        txn(32'h80000010, 32'h0, 1'b0, 4'h0, 3'b001, 11'd14, acc, early, k, e, rv, tg);
        n_checks++; if (k !== 1'b1 || e !== 1'b0 || rv !== 32'h0 || tg !== 11'd14) begin
            n_fail++; $display("FAIL maint_flush: got ack %0h err %0h rdata %h tag %0d want 1/0/0/14", k, e, rv, tg);
        end
        txn(32'h80000010, 32'h0, 1'b0, 4'h0, 3'b110, 11'd15, acc, early, k, e, rv, tg);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_inv_wb: got err %0h want 1", e); end
        txn(32'h80000010, 32'h99999999, 1'b0, 4'hF, 3'b001, 11'd16, acc, early, k, e, rv, tg);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_st_flush: got err %0h want 1", e); end
        txn(32'h80000010, 32'h0, 1'b1, 4'h0, 3'b000, 11'd17, acc, early, k, e, rv, tg);
        n_checks++; if (rv !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_no_write: got %h want deadbeef", rv); end
    endtask

    task automatic test_back_to_back;
        idle;
        tick;
        for (int i = 0; i < 11; i++) begin
            if (i >= 3 && i <= 8) begin
                n_checks++; if (ack !== 1'b1 || resp_tag !== 11'(20 + i - 3) || rdata !== 32'hDEADBEEF) begin
                    n_fail++; $display("FAIL b2b_ack%0d: got ack %0h tag %0d rdata %h want 1/%0d/deadbeef", i, ack, resp_tag, rdata, 20 + i - 3);
                end
            end else begin
                n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL b2b_noack%0d: got %0h want 0", i, ack); end
            end
            if (i < 6) begin
                addr = 32'h80000010; rd = 1'b1; req_tag = 11'(20 + i);
            end else begin
                idle;
            end
            #1;
            if (i < 6) begin
                n_checks++; if (accept !== 1'b1) begin n_fail++; $display("FAIL b2b_accept%0d: got %0h want 1", i, accept); end
            end
            tick;
        end
    endtask

    task automatic test_queue_full;
        int exp_iter[6] = '{9, 10, 11, 12, 18, 19};
        int sent = 0;
        int got = 0;
        q_addr = 32'h80000000;
        q_rd = 1'b0;
        tick;
        for (int i = 0; i < 23; i++) begin
            if (got < 6 && i == exp_iter[got]) begin
                n_checks++; if (q_ack !== 1'b1 || q_resp_tag !== 11'(got) || q_err !== 1'b0) begin
                    n_fail++; $display("FAIL qf_ack%0d: got ack %0h tag %0d err %0h want 1/%0d/0", i, q_ack, q_resp_tag, q_err, got);
                end
                got++;
            end else begin
                n_checks++; if (q_ack !== 1'b0) begin n_fail++; $display("FAIL qf_noack%0d: got %0h want 0", i, q_ack); end
            end
            q_rd = (sent < 6);
            q_tag = 11'(sent);
            #1;
            if (sent < 6) begin
                n_checks++; if (q_accept !== (i < 4 || i >= 9)) begin
                    n_fail++; $display("FAIL qf_accept%0d: got %0h want %0h", i, q_accept, (i < 4 || i >= 9));
                end
                if (q_accept) sent++;
            end
            tick;
        end
        q_rd = 1'b0;
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL qf_ack_count: got %0d want 6", got); end
    endtask

    task automatic test_stall;
        idle;
        tick;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) begin
                n_checks++; if (ack !== 1'b1 || resp_tag !== 11'd30 || rdata !== 32'hDEADBEEF) begin
                    n_fail++; $display("FAIL stall_ack: got ack %0h tag %0d rdata %h want 1/30/deadbeef", ack, resp_tag, rdata);
                end
            end else begin
                n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL stall_noack%0d: got %0h want 0", i, ack); end
            end
            if (i <= 3) begin
                addr = 32'h80000010; rd = 1'b1; req_tag = 11'd30;
            end else begin
                idle;
            end
            stall = (i < 3);
            #1;
            if (i <= 3) begin
                n_checks++; if (accept !== (i == 3)) begin n_fail++; $display("FAIL stall_accept%0d: got %0h want %0h", i, accept, (i == 3)); end
            end
            tick;
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_midflight;
        logic acc, early, k, e;
        logic [31:0] rv;
        logic [10:0] tg;
        idle;
        tick;
        addr = 32'h80000020; rd = 1'b1; req_tag = 11'd40;
        #1;
        n_checks++; if (accept !== 1'b1) begin n_fail++; $display("FAIL rm_accept0: got %0h want 1", accept); end
        tick;
        req_tag = 11'd41;
        #1;
        n_checks++; if (accept !== 1'b1) begin n_fail++; $display("FAIL rm_accept1: got %0h want 1", accept); end
        tick;
        idle;
        rst = 1'b1;
        #1;
        n_checks++; if (accept !== 1'b0) begin n_fail++; $display("FAIL rm_accept_rst: got %0h want 0", accept); end
        tick;
        n_checks++; if (ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || resp_tag !== 11'h0) begin
            n_fail++; $display("FAIL rm_outputs_rst: got ack %0h err %0h rdata %h tag %h want all 0", ack, err, rdata, resp_tag);
        end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rm_dropped%0d: got ack %0h tag %0d want 0", i, ack, resp_tag); end
            tick;
        end
        txn(32'h80000020, 32'h0, 1'b1, 4'h0, 3'b000, 11'd42, acc, early, k, e, rv, tg);
        n_checks++; if (k !== 1'b1 || rv !== 32'hEEAA33FF || tg !== 11'd42) begin
            n_fail++; $display("FAIL rm_preserved: got ack %0h rdata %h tag %0d want 1/eeaa33ff/42", k, rv, tg);
        end
        txn(32'h80000010, 32'h0, 1'b1, 4'h0, 3'b000, 11'd43, acc, early, k, e, rv, tg);
        n_checks++; if (rv !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rm_preserved2: got %h want deadbeef", rv); end
    endtask

    initial begin
        idle;
        stall = 1'b0;
        q_addr = 32'h0;
        q_rd = 1'b0;
        q_tag = 11'h0;
        test_reset;
        test_store_load;
        test_byte_strobe;
        test_range;
        test_errors;
        test_back_to_back;
        test_queue_full;
        test_stall;
        test_reset_midflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
